fork_join_ctrl: RTL and testbench

FORK_JOIN_CTRL -- requirements
Module: fork_join_ctrl

---
 rtl/fork_join_pkg.sv | 23 ++
 rtl/fj_channel.sv | 48 ++++
 rtl/fork_join_ctrl.sv | 126 ++++++++++++
 tb/tb_fork_join_ctrl.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/fork_join_pkg.sv
// Shared types for the fork/join controller: join modes, FSM states and
// the helper that folds the reserved mode encoding onto JOIN_ALL.
// Pure declarations, no logic.
package fork_join_pkg;

  typedef enum logic [1:0] {
    JOIN_ALL  = 2'b00,
    JOIN_ANY  = 2'b01,
    JOIN_NONE = 2'b10
  } join_mode_e;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    RUN   = 2'b01,
    DRAIN = 2'b10
  } fsm_state_e;

  // Encoding 2'b11 is reserved and behaves like JOIN_ALL.
  function automatic join_mode_e decode_mode(input logic [1:0] m);
    return (m == 2'b11) ? JOIN_ALL : join_mode_e'(m);
  endfunction

endpackage

// File: rtl/fj_channel.sv
// One fork channel: a down-counter loaded with max(dur,1) that runs to completion.
// Latency: done pulses max(dur,1) cycles after the load edge; active drops in that same cycle.
// No backpressure; kill abandons the count at the next edge without a done pulse.
module fj_channel
  import fork_join_pkg::*;
#(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [CNT_W-1:0] load_dur,
  input  logic             kill,
  output logic             active,
  output logic             done
);

  logic             run;
  logic [CNT_W-1:0] cnt;
  logic             last;

  // cnt holds the number of cycles left including the current one.
  assign last   = (cnt == CNT_W'(1));
  assign done   = run & last & ~kill;
  assign active = run & ~last;

  // Counter: kill wins, then load, then count down and stop on the last cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (kill) begin
      run <= 1'b0;
      cnt <= '0;
    end else if (load) begin
      run <= 1'b1;
      cnt <= (load_dur == '0) ? CNT_W'(1) : load_dur;
    end else if (run) begin
      if (last) begin
        run <= 1'b0;
        cnt <= '0;
      end else begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches N_CH timed channels and signals join_done per join mode.
// Latency: join_done at T+1 (JOIN_NONE / no channels) or in the deciding ch_done cycle.
// No backpressure; start outside IDLE is dropped. FJ_DISABLE_FORK_EN adds disable_fork.
module fork_join_ctrl
  import fork_join_pkg::*;
#(
  parameter int N_CH  = 4,
  parameter int CNT_W = 8
) (
  input  logic                    clk,
  input  logic                    rst_n,
`ifdef FJ_DISABLE_FORK_EN
  input  logic                    disable_fork,
`endif
  input  logic                    start,
  input  logic [1:0]              mode,
  input  logic [N_CH-1:0]         ch_en,
  input  logic [N_CH*CNT_W-1:0]   dur,
  output logic                    busy,
  output logic [N_CH-1:0]         ch_active,
  output logic [N_CH-1:0]         ch_done,
  output logic                    join_done,
  output logic [$clog2(N_CH)-1:0] first_id
);

  localparam int ID_W = $clog2(N_CH);

`ifndef FJ_DISABLE_FORK_EN
  logic disable_fork;
  assign disable_fork = 1'b0;
`endif

  fsm_state_e state, state_nxt;
  join_mode_e mode_q;
  logic       start_ok;
  logic       kill;
  logic       remaining;
  logic       any_done;
  logic       fire;
  logic [ID_W-1:0] low_id;
  logic [ID_W-1:0] first_id_q;

  assign start_ok  = start & (state == IDLE);
  assign remaining = |ch_active;
  assign any_done  = |ch_done;
  assign busy      = (state != IDLE);
  assign first_id  = join_done ? low_id : first_id_q;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    fj_channel #(.CNT_W(CNT_W)) u_ch (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (start_ok & ch_en[g]),
      .load_dur (dur[g*CNT_W +: CNT_W]),
      .kill     (kill),
      .active   (ch_active[g]),
      .done     (ch_done[g])
    );
  end

  // Lowest-index channel completing this cycle; 0 when none completes.
  always_comb begin
    low_id = '0;
    for (int i = N_CH - 1; i >= 0; i--) begin
      if (ch_done[i]) low_id = ID_W'(i);
    end
  end

  // Join condition while RUN is pending; an empty launch satisfies every mode at once.
  always_comb begin
    fire = 1'b0;
    unique case (mode_q)
      JOIN_ANY:  fire = any_done | ~remaining;
      JOIN_NONE: fire = 1'b1;
      default:   fire = ~remaining;
    endcase
  end

  // Next state, join pulse and channel kill.
  always_comb begin
    state_nxt = state;
    join_done = 1'b0;
    kill      = 1'b0;
    unique case (state)
      IDLE: begin
        if (start_ok) state_nxt = RUN;
      end
      RUN: begin
        if (disable_fork) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else if (fire) begin
          join_done = 1'b1;
          state_nxt = remaining ? DRAIN : IDLE;
        end
      end
      DRAIN: begin
        if (disable_fork) begin
          kill      = 1'b1;
          state_nxt = IDLE;
        end else if (!remaining) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Mode captured at launch; first_id captured when the join fires and held afterwards.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q     <= JOIN_ALL;
      first_id_q <= '0;
    end else begin
      if (start_ok)  mode_q     <= decode_mode(mode);
      if (join_done) first_id_q <= low_id;
    end
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Scoreboard bench for fork_join_ctrl: expected events (ch_done, join_done, busy edges)
// are derived from launch parameters, observed events are collected at negedge.
// Event key = cycle*1000 + kind*100 + id; kind 0 ch_done, 1 join_done, 2 busy rise, 3 busy fall.
module tb_fork_join_ctrl;

  localparam int N_CH  = 4;
  localparam int CNT_W = 8;

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic [1:0]            mode;
  logic [N_CH-1:0]       ch_en;
  logic [N_CH*CNT_W-1:0] dur;
  logic                  busy;
  logic [N_CH-1:0]       ch_active;
  logic [N_CH-1:0]       ch_done;
  logic                  join_done;
  logic [1:0]            first_id;
`ifdef FJ_DISABLE_FORK_EN
  logic                  disable_fork;
`endif

  fork_join_ctrl #(.N_CH(N_CH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
`ifdef FJ_DISABLE_FORK_EN
    .disable_fork (disable_fork),
`endif
    .start     (start),
    .mode      (mode),
    .ch_en     (ch_en),
    .dur       (dur),
    .busy      (busy),
    .ch_active (ch_active),
    .ch_done   (ch_done),
    .join_done (join_done),
    .first_id  (first_id)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc   = 0;
  int exp_q[$];
  int obs_q[$];
  logic busy_prev = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Monitor: record every output event with the cycle it is visible in.
  always @(negedge clk) begin
    for (int i = 0; i < N_CH; i++)
      if (ch_done[i]) obs_q.push_back(cyc * 1000 + i);
    if (join_done) obs_q.push_back(cyc * 1000 + 100 + int'(first_id));
    if (busy && !busy_prev) obs_q.push_back(cyc * 1000 + 200);
    if (!busy && busy_prev) obs_q.push_back(cyc * 1000 + 300);
    busy_prev <= busy;
  end

  task automatic chk(input string tag, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  task automatic compare_sb(input string tag);
    int n;
    exp_q.sort();
    obs_q.sort();
    chk({tag, "_nev"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_ev"}, obs_q[i], exp_q[i]);
  endtask

  task automatic drive_start(input logic [1:0] md, input logic [3:0] en,
                             input int d0, input int d1, input int d2, input int d3);
    start = 1'b1;
    mode  = md;
    ch_en = en;
    dur   = {8'(d3), 8'(d2), 8'(d1), 8'(d0)};
  endtask

  int last_fid = 0;

  // One launch: expected events from the join rules, optional ignored start at T+ign.
  task automatic run_case(input string tag, input logic [1:0] md, input logic [3:0] en,
                          input int d0, input int d1, input int d2, input int d3, input int ign);
    int d[4];
    int ec[4];
    int t, jc, fid, last, fall, guard;
    bit found;
    d[0] = d0; d[1] = d1; d[2] = d2; d[3] = d3;
    @(posedge clk); #1;
    obs_q.delete();
    exp_q.delete();
    t = cyc;
    drive_start(md, en, d0, d1, d2, d3);
    for (int i = 0; i < N_CH; i++) ec[i] = t + ((d[i] < 1) ? 1 : d[i]);
    if (en == 4'b0) jc = t + 1;
    else if (md == 2'b10) jc = t + 1;
    else if (md == 2'b01) begin
      jc = 1 << 30;
      for (int i = 0; i < N_CH; i++) if (en[i] && ec[i] < jc) jc = ec[i];
    end else begin
      jc = 0;
      for (int i = 0; i < N_CH; i++) if (en[i] && ec[i] > jc) jc = ec[i];
    end
    fid = 0; found = 0; last = jc;
    for (int i = 0; i < N_CH; i++) begin
      if (en[i]) begin
        exp_q.push_back(ec[i] * 1000 + i);
        if (ec[i] > last) last = ec[i];
        if (ec[i] == jc && !found) begin fid = i; found = 1; end
      end
    end
    fall = last + 1;
    exp_q.push_back(jc * 1000 + 100 + fid);
    exp_q.push_back((t + 1) * 1000 + 200);
    exp_q.push_back(fall * 1000 + 300);
    @(posedge clk); #1;
    start = 1'b0;
    if (ign > 0) begin
      repeat (ign - 1) @(posedge clk);
      #1;
      drive_start(2'b00, 4'hF, 2, 2, 2, 2);
      @(posedge clk); #1;
      start = 1'b0;
    end
    guard = 0;
    while (cyc < fall + 2 && guard < 1000) begin
      @(negedge clk);
      guard++;
    end
    compare_sb(tag);
    chk({tag, "_fid_hold"}, int'(first_id), fid);
    last_fid = fid;
  endtask

  initial begin
    int t;
    rst_n = 1'b0;
    start = 1'b0;
    mode  = 2'b00;
    ch_en = '0;
    dur   = '0;
`ifdef FJ_DISABLE_FORK_EN
    disable_fork = 1'b0;
`endif
    #12;
    chk("rst_busy",      int'(busy),      0);
    chk("rst_ch_active", int'(ch_active), 0);
    chk("rst_ch_done",   int'(ch_done),   0);
    chk("rst_join_done", int'(join_done), 0);
    chk("rst_first_id",  int'(first_id),  0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // mode, ch_en, dur0..dur3, ignored-start offset
    run_case("any_2ch",    2'b01, 4'b0011, 20, 30, 0, 0, 0);
    run_case("all_4ch",    2'b00, 4'b1111, 5, 9, 3, 7, 0);
    run_case("none_2ch",   2'b10, 4'b0011, 4, 0, 0, 0, 0);
    run_case("any_ignore", 2'b01, 4'b1010, 0, 6, 0, 6, 3);
    run_case("empty_all",  2'b00, 4'b0000, 3, 3, 3, 3, 0);
    run_case("empty_any",  2'b01, 4'b0000, 3, 3, 3, 3, 0);
    run_case("empty_none", 2'b10, 4'b0000, 3, 3, 3, 3, 0);
    run_case("mode11_all", 2'b11, 4'b0111, 2, 8, 4, 0, 0);
    run_case("any_simul",  2'b01, 4'b1100, 9, 9, 3, 3, 0);
    run_case("all_dur1",   2'b00, 4'b1001, 1, 0, 0, 0, 0);
    run_case("none_maxd",  2'b10, 4'b0100, 0, 0, 255, 0, 0);

    // Reset in the middle of a JOIN_ALL launch.
    @(posedge clk); #1;
    t = cyc;
    drive_start(2'b00, 4'hF, 10, 10, 10, 10);
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t + 4) @(posedge clk);
    #1;
    chk("pre_rst_active", int'(ch_active), 15);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy",      int'(busy),      0);
    chk("mid_rst_ch_active", int'(ch_active), 0);
    chk("mid_rst_ch_done",   int'(ch_done),   0);
    chk("mid_rst_join_done", int'(join_done), 0);
    chk("mid_rst_first_id",  int'(first_id),  0);
    repeat (2) @(negedge clk);
    obs_q.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (15) @(posedge clk);
    chk("post_rst_quiet", obs_q.size(), 0);

`ifdef FJ_DISABLE_FORK_EN
    // disable_fork during RUN: channels dropped silently, no join.
    @(posedge clk); #1;
    obs_q.delete();
    exp_q.delete();
    t = cyc;
    drive_start(2'b00, 4'hF, 10, 10, 10, 10);
    exp_q.push_back((t + 1) * 1000 + 200);
    exp_q.push_back((t + 6) * 1000 + 300);
    @(posedge clk); #1;
    start = 1'b0;
    while (cyc < t + 5) @(posedge clk);
    #1;
    disable_fork = 1'b1;
    @(negedge clk);
    chk("dis_active_before", int'(ch_active), 15);
    @(posedge clk); #1;
    disable_fork = 1'b0;
    @(negedge clk);
    chk("dis_active_after", int'(ch_active), 0);
    chk("dis_busy_after",   int'(busy),      0);
    while (cyc < t + 16) @(negedge clk);
    compare_sb("disable");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
